// File: rtl/demorgan_checker.sv
// demorgan_checker
// Sweeps the four A/B input combinations through an external De Morgan unit,
// compares each 6-bit response against the ideal one, and reports the
// per-vector failure mask, a failure count and an overall pass flag.
// Optional feature: define DEMORGAN_CHK_FIRSTFAIL_EN to capture the index and
// mismatch bits of the first failing vector of each sweep. Without it those
// outputs are tied to zero.
module demorgan_checker #(
    parameter int SETTLE_CYCLES = 1    // wait cycles between drive and check, 0..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    input  logic [5:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [1:0] first_fail_vec,
    output logic [5:0] first_fail_bits
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // The settle counter is loaded with the last count value and runs down to 0.
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t     r_state;
    logic [1:0] r_vec;
    logic [3:0] r_settle_cnt;
    logic       r_dut_a;
    logic       r_dut_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err_count;
    logic [3:0] r_fail_mask;

    logic [5:0] w_expected;
    logic [5:0] w_mismatch;
    logic       w_fail;
    logic [2:0] w_err_next;
    logic [1:0] w_vec_next;
    logic       w_accept;
    logic       w_abort;

    // Ideal response for the stimulus currently on the bus:
    // {nA, nB, nA&nB, nA|nB, ~(A&B), ~(A|B)}.
    assign w_expected = {~r_dut_a, ~r_dut_b, ~r_dut_a & ~r_dut_b, ~r_dut_a | ~r_dut_b,
                         ~(r_dut_a & r_dut_b), ~(r_dut_a | r_dut_b)};
    assign w_mismatch = dut_out ^ w_expected;
    assign w_fail     = |w_mismatch;
    assign w_err_next = r_err_count + {2'b00, w_fail};
    assign w_vec_next = r_vec + 2'd1;

    // Start is honoured only when no sweep is running, so abort (which is only
    // meaningful while busy) can never collide with an accepted start.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_abort  = abort && r_busy;

    // Sweep sequencer: drives the stimulus, times the settle window and
    // accumulates the per-vector results into registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register, including the result counters, is cleared by
        // the asynchronous reset so outputs drop to zero without a clock.
        if (reset) begin
            r_state      <= ST_IDLE;
            r_vec        <= 2'd0;
            r_settle_cnt <= 4'd0;
            r_dut_a      <= 1'b0;
            r_dut_b      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= 3'd0;
            r_fail_mask  <= 4'd0;
        end else if (w_accept) begin
            r_state      <= ST_DRIVE;
            r_vec        <= 2'd0;
            r_settle_cnt <= SETTLE_LAST;
            r_dut_a      <= 1'b0;
            r_dut_b      <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= 3'd0;
            r_fail_mask  <= 4'd0;
        end else if (w_abort) begin
            // Partial results stay visible; only the bus and status drop.
            r_state <= ST_IDLE;
            r_dut_a <= 1'b0;
            r_dut_b <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                ST_DRIVE: begin
                    r_settle_cnt <= SETTLE_LAST;
                    r_state      <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == 4'd0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    r_err_count <= w_err_next;
                    if (w_fail) begin
                        r_fail_mask[r_vec] <= 1'b1;
                    end
                    if (r_vec == 2'd3) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 3'd0);
                        r_dut_a <= 1'b0;
                        r_dut_b <= 1'b0;
                    end else begin
                        r_state <= ST_DRIVE;
                        r_vec   <= w_vec_next;
                        r_dut_a <= w_vec_next[1];
                        r_dut_b <= w_vec_next[0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dut_a     = r_dut_a;
    assign dut_b     = r_dut_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_mask = r_fail_mask;

`ifdef DEMORGAN_CHK_FIRSTFAIL_EN
    logic [1:0] r_first_vec;
    logic [5:0] r_first_bits;

    // Latch the first failing vector of a sweep; cleared on each accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_vec  <= 2'd0;
            r_first_bits <= 6'd0;
        end else if (w_accept) begin
            r_first_vec  <= 2'd0;
            r_first_bits <= 6'd0;
        end else if (!w_abort && (r_state == ST_CHECK) && w_fail && (r_err_count == 3'd0)) begin
            r_first_vec  <= r_vec;
            r_first_bits <= w_mismatch;
        end
    end

    assign first_fail_vec  = r_first_vec;
    assign first_fail_bits = r_first_bits;
`else
    assign first_fail_vec  = 2'd0;
    assign first_fail_bits = 6'd0;
`endif

endmodule

// File: tb/tb_demorgan_checker.sv
// tb_demorgan_checker
// Two checker instances (SETTLE_CYCLES=1 and SETTLE_CYCLES=0) each drive a
// behavioural De Morgan unit whose response can be corrupted per vector.
// Expected outputs come from a truth-table model of the sweep.
module tb_demorgan_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start     [2];
    logic       abort     [2];
    logic       dut_a     [2];
    logic       dut_b     [2];
    logic [5:0] dut_out   [2];
    logic       busy      [2];
    logic       done      [2];
    logic       pass      [2];
    logic [2:0] err_count [2];
    logic [3:0] fail_mask [2];
    logic [1:0] ffv       [2];
    logic [5:0] ffb       [2];

    // Per-instance, per-vector XOR corruption applied by the behavioural unit.
    logic [5:0] flip [2][4];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demorgan_checker #(.SETTLE_CYCLES(1)) u_chk1 (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .dut_a(dut_a[0]), .dut_b(dut_b[0]), .dut_out(dut_out[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err_count[0]), .fail_mask(fail_mask[0]),
        .first_fail_vec(ffv[0]), .first_fail_bits(ffb[0])
    );

    demorgan_checker #(.SETTLE_CYCLES(0)) u_chk0 (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .dut_a(dut_a[1]), .dut_b(dut_b[1]), .dut_out(dut_out[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err_count[1]), .fail_mask(fail_mask[1]),
        .first_fail_vec(ffv[1]), .first_fail_bits(ffb[1])
    );

    // Ideal De Morgan response for vector v = 2*A + B, from truth-table rules.
    function automatic logic [5:0] good_resp(input int v);
        logic a, b;
        a = (v >= 2);
        b = (v % 2 == 1);
        return {!a, !b, !a && !b, !a || !b, !(a && b), !(a || b)};
    endfunction

    // Behavioural unit under test, with optional per-vector corruption.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dut_out[i] = good_resp(int'({dut_a[i], dut_b[i]})) ^ flip[i][{dut_a[i], dut_b[i]}];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flips(input int i);
        for (int v = 0; v < 4; v++) flip[i][v] = 6'd0;
    endtask

    // One full sweep on instance i, checked cycle by cycle and at the end.
    task automatic do_sweep(input int i, input string name);
        int p, err, v_exp;
        logic [3:0] mask;
        logic [1:0] fv;
        logic [5:0] fb;
        bit found;
        p = (i == 0) ? 3 : 2;
        err = 0; mask = 4'd0; fv = 2'd0; fb = 6'd0; found = 0;
        for (int v = 0; v < 4; v++) begin
            if (flip[i][v] != 6'd0) begin
                err++;
                mask[v] = 1'b1;
                if (!found) begin
                    found = 1;
                    fv = 2'(v);
                    fb = flip[i][v];
                end
            end
        end
`ifndef DEMORGAN_CHK_FIRSTFAIL_EN
        fv = 2'd0;
        fb = 6'd0;
`endif
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        for (int k = 0; k <= 4 * p; k++) begin
            if (k > 0) tick();
            v_exp = (k < 4 * p) ? k / p : 0;
            vectors++;
            if ({dut_a[i], dut_b[i]} !== 2'(v_exp)) begin
                miscompares++;
                $display("FAIL %s ab cycle %0d: got %b expected %b", name, k, {dut_a[i], dut_b[i]}, 2'(v_exp));
            end
            vectors++;
            if (busy[i] !== (k < 4 * p)) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, busy[i], (k < 4 * p));
            end
            vectors++;
            if (done[i] !== (k == 4 * p)) begin
                miscompares++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, k, done[i], (k == 4 * p));
            end
        end
        vectors++;
        if (err_count[i] !== 3'(err)) begin
            miscompares++;
            $display("FAIL %s err_count: got %0d expected %0d", name, err_count[i], err);
        end
        vectors++;
        if (fail_mask[i] !== mask) begin
            miscompares++;
            $display("FAIL %s fail_mask: got %b expected %b", name, fail_mask[i], mask);
        end
        vectors++;
        if (pass[i] !== (err == 0)) begin
            miscompares++;
            $display("FAIL %s pass: got %b expected %b", name, pass[i], (err == 0));
        end
        vectors++;
        if (ffv[i] !== fv) begin
            miscompares++;
            $display("FAIL %s first_fail_vec: got %0d expected %0d", name, ffv[i], fv);
        end
        vectors++;
        if (ffb[i] !== fb) begin
            miscompares++;
            $display("FAIL %s first_fail_bits: got %b expected %b", name, ffb[i], fb);
        end
    endtask

    // Every output of both instances must be zero.
    task automatic expect_all_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({dut_a[i], dut_b[i], busy[i], done[i], pass[i], err_count[i], fail_mask[i],
                 ffv[i], ffb[i]} !== 22'd0) begin
                miscompares++;
                $display("FAIL %s inst%0d: got ab=%b busy=%b done=%b pass=%b err=%0d mask=%b ffv=%0d ffb=%b expected all 0",
                         name, i, {dut_a[i], dut_b[i]}, busy[i], done[i], pass[i], err_count[i],
                         fail_mask[i], ffv[i], ffb[i]);
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1 expect_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        expect_all_zero("after_reset");
    endtask

    task automatic test_clean();
        clear_flips(0);
        do_sweep(0, "clean_s1");
        clear_flips(1);
        do_sweep(1, "clean_s0");
    endtask

    task automatic test_stuck_bit1();
        for (int v = 0; v < 4; v++) flip[0][v] = good_resp(v) & 6'b000010;
        do_sweep(0, "stuck_bit1");
        clear_flips(0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int i;
            i = r % 2;
            for (int v = 0; v < 4; v++) begin
                flip[i][v] = ($urandom_range(2) == 0) ? 6'($urandom_range(63)) : 6'd0;
            end
            do_sweep(i, (i == 0) ? "random_s1" : "random_s0");
            clear_flips(i);
        end
    endtask

    task automatic test_abort();
        clear_flips(0);
        flip[0][0] = 6'b000001;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 7; k++) tick();  // k=7: vector 2, settle
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        vectors++;
        if ({busy[0], done[0], dut_a[0], dut_b[0]} !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort status: got busy=%b done=%b ab=%b expected 0 0 00",
                     busy[0], done[0], {dut_a[0], dut_b[0]});
        end
        vectors++;
        if ({err_count[0], fail_mask[0]} !== {3'd1, 4'b0001}) begin
            miscompares++;
            $display("FAIL abort held counters: got err=%0d mask=%b expected 1 0001",
                     err_count[0], fail_mask[0]);
        end
        tick();
        tick();
        vectors++;
        if (busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort stays idle: got busy=%b expected 0", busy[0]);
        end
        clear_flips(0);
        do_sweep(0, "after_abort");
    endtask

    task automatic test_reset_mid_sweep();
        flip[0][0] = 6'b100000;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 4; k++) tick();  // k=4: vector 1, settle
        reset = 1'b1;
        #1 expect_all_zero("mid_reset");
        #2 reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({busy[0], done[0]} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset idle: got busy=%b done=%b expected 0 0", busy[0], done[0]);
        end
        clear_flips(0);
        do_sweep(0, "after_mid_reset");
    endtask

    task automatic test_back_to_back();
        clear_flips(0);
        start[0] = 1'b1;
        tick();
        for (int k = 1; k <= 25; k++) begin  // P=3: done at 12 and again at 25
            tick();
            if (k == 13) start[0] = 1'b0;
            vectors++;
            if (done[0] !== ((k == 12) || (k == 25))) begin
                miscompares++;
                $display("FAIL b2b done cycle %0d: got %b expected %b", k, done[0], ((k == 12) || (k == 25)));
            end
            if (k == 13) begin
                vectors++;
                if ({busy[0], dut_a[0], dut_b[0]} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL b2b restart: got busy=%b ab=%b expected 1 00", busy[0], {dut_a[0], dut_b[0]});
                end
            end
        end
        vectors++;
        if (pass[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b pass: got %b expected 1", pass[0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            clear_flips(i);
        end
        test_reset();
        test_clean();
        test_stuck_bit1();
        test_abort();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
